// File: rtl/jt10_mix_pkg.sv
// jt10_mix_pkg: shared FSM state type and gain fixed-point constants for the mixer
package jt10_mix_pkg;
  typedef enum logic [1:0] {IDLE, ACC, OUT} state_e;
  localparam int GAIN_UNITY = 'h10;
  localparam int GAIN_FRAC = 4;
endpackage

// File: rtl/jt10_mix_sat.sv
// jt10_mix_sat: clamps a signed WIN-bit value to the signed WOUT-bit range
module jt10_mix_sat #(
  parameter int WIN = 25,
  parameter int WOUT = 16
) (
  input  logic signed [WIN-1:0]  din_i,
  output logic signed [WOUT-1:0] dout_o,
  output logic                   ovf_o
);
  logic [WIN-WOUT:0] hi;
  // value fits only when every bit above the output MSB matches the sign
  assign hi = din_i[WIN-1:WOUT-1];
  assign ovf_o = !(&hi || !(|hi));
  assign dout_o = ovf_o ? {din_i[WIN-1], {(WOUT-1){~din_i[WIN-1]}}} : din_i[WOUT-1:0];
endmodule

// File: rtl/jt10_mixer.sv
// jt10_mixer: sequential stereo mixer, one source multiply-accumulate per cen cycle
module jt10_mixer
  import jt10_mix_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int WI = 16,
  parameter int WO = 16,
  parameter int GW = 8,
  localparam int IW = NSRC > 1 ? $clog2(NSRC) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen,
  input  logic                 sample,
  input  logic [NSRC*WI-1:0]   src_l,
  input  logic [NSRC*WI-1:0]   src_r,
  input  logic [NSRC-1:0]      src_en,
  input  logic                 gain_we,
  input  logic [IW-1:0]        gain_addr,
  input  logic [GW-1:0]        gain_din,
  output logic signed [WO-1:0] snd_left,
  output logic signed [WO-1:0] snd_right,
  output logic                 snd_sample,
  output logic                 busy,
  output logic                 ovf,
  output logic                 drop,
  input  logic                 flag_clr
);
  localparam int AW = WI + GW + $clog2(NSRC) + 1;
  localparam logic [IW-1:0] LAST = IW'(NSRC - 1);
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic signed [AW-1:0] accl_q, accl_d, accr_q, accr_d, pl, pr, shl, shr;
  logic signed [WI-1:0] fl_q [NSRC];
  logic signed [WI-1:0] fr_q [NSRC];
  logic [GW-1:0] gain_q [NSRC];
  logic [GW-1:0] fg_q [NSRC];
  logic [NSRC-1:0] fen_q;
  logic signed [WO-1:0] satl, satr, left_q, right_q;
  logic ovl, ovr, load, emit, sample_q, ovf_q, drop_q;
  // gains are unsigned, so widen with a zero MSB before the signed multiply
  assign pl = AW'(fl_q[idx_q]) * AW'($signed({1'b0, fg_q[idx_q]}));
  assign pr = AW'(fr_q[idx_q]) * AW'($signed({1'b0, fg_q[idx_q]}));
  assign shl = accl_q >>> GAIN_FRAC;
  assign shr = accr_q >>> GAIN_FRAC;
  jt10_mix_sat #(.WIN(AW), .WOUT(WO)) u_sat_l (.din_i(shl), .dout_o(satl), .ovf_o(ovl));
  jt10_mix_sat #(.WIN(AW), .WOUT(WO)) u_sat_r (.din_i(shr), .dout_o(satr), .ovf_o(ovr));
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    accl_d = accl_q;
    accr_d = accr_q;
    load = 1'b0;
    emit = 1'b0;
    if (cen) begin
      case (state_q)
        IDLE: if (sample) begin
          state_d = ACC;
          idx_d = '0;
          accl_d = '0;
          accr_d = '0;
          load = 1'b1;
        end
        ACC: begin
          accl_d = accl_q + (fen_q[idx_q] ? pl : '0);
          accr_d = accr_q + (fen_q[idx_q] ? pr : '0);
          idx_d = idx_q + 1'b1;
          state_d = idx_q == LAST ? OUT : ACC;
        end
        OUT: begin
          emit = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      accl_q <= '0;
      accr_q <= '0;
      left_q <= '0;
      right_q <= '0;
      sample_q <= 1'b0;
      ovf_q <= 1'b0;
      drop_q <= 1'b0;
      for (int i = 0; i < NSRC; i++) gain_q[i] <= GW'(GAIN_UNITY);
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      accl_q <= accl_d;
      accr_q <= accr_d;
      left_q <= emit ? satl : left_q;
      right_q <= emit ? satr : right_q;
      sample_q <= emit;
      ovf_q <= (emit && (ovl || ovr)) || (ovf_q && !flag_clr);
      drop_q <= (sample && busy) || (drop_q && !flag_clr);
      if (gain_we && 32'(gain_addr) < NSRC) gain_q[gain_addr] <= gain_din;
    end
  end
  always_ff @(posedge clk) begin
    if (load) begin
      fen_q <= src_en;
      for (int i = 0; i < NSRC; i++) begin
        fl_q[i] <= src_l[i*WI +: WI];
        fr_q[i] <= src_r[i*WI +: WI];
        fg_q[i] <= gain_q[i];
      end
    end
  end
  assign busy = state_q != IDLE;
  assign snd_left = left_q;
  assign snd_right = right_q;
  assign snd_sample = sample_q;
  assign ovf = ovf_q;
  assign drop = drop_q;
endmodule
